// File: rtl/cpu_control.sv
// rtl/cpu_control.sv - multi-cycle control FSM for a small RV32 subset core
module cpu_control #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic [31:0] alu_cntrl,
  output logic        alu_src_imm,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_inc,
  output logic        pc_branch,
  output logic        reg_write,
  output logic        wb_sel,
  output logic        trap,
  output logic [31:0] retired
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEMORY    = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_TRAP      = 3'd5;

  localparam logic [1:0] C_ALU    = 2'd0;
  localparam logic [1:0] C_LOAD   = 2'd1;
  localparam logic [1:0] C_STORE  = 2'd2;
  localparam logic [1:0] C_BRANCH = 2'd3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  logic [2:0] state, state_nxt;
  logic [1:0] cls;
  logic       dec_legal, dec_imm;
  logic [2:0] dec_op;
  logic [1:0] dec_cls;
  logic       retire;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // Register and immediate fields are consumed by the datapath, not here.
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  always_comb begin
    dec_legal = 1'b0;
    dec_imm   = 1'b0;
    dec_op    = OP_ADD;
    dec_cls   = C_ALU;
    case (opcode)
      7'b0110011: begin
        case (funct3)
          3'b000: begin
            if (funct7 == 7'b0000000) begin
              dec_legal = 1'b1;
              dec_op    = OP_ADD;
            end else if (funct7 == 7'b0100000) begin
              dec_legal = 1'b1;
              dec_op    = OP_SUB;
            end
          end
          3'b100: begin dec_legal = (funct7 == 7'b0000000); dec_op = OP_XOR; end
          3'b110: begin dec_legal = (funct7 == 7'b0000000); dec_op = OP_OR;  end
          3'b111: begin dec_legal = (funct7 == 7'b0000000); dec_op = OP_AND; end
          default: ;
        endcase
      end
      7'b0010011: begin
        dec_imm = 1'b1;
        case (funct3)
          3'b000: begin dec_legal = 1'b1; dec_op = OP_ADD; end
          3'b100: begin dec_legal = 1'b1; dec_op = OP_XOR; end
          3'b110: begin dec_legal = 1'b1; dec_op = OP_OR;  end
          3'b111: begin dec_legal = 1'b1; dec_op = OP_AND; end
          default: ;
        endcase
      end
      7'b0000011: begin
        dec_legal = (funct3 == 3'b010);
        dec_imm   = 1'b1;
        dec_cls   = C_LOAD;
      end
      7'b0100011: begin
        dec_legal = (funct3 == 3'b010);
        dec_imm   = 1'b1;
        dec_cls   = C_STORE;
      end
      7'b1100011: begin
        dec_legal = (funct3 == 3'b000);
        dec_op    = OP_SUB;
        dec_cls   = C_BRANCH;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:     if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        if (dec_legal)            state_nxt = S_EXECUTE;
        else if (TRAP_ON_ILLEGAL) state_nxt = S_TRAP;
        else                      state_nxt = S_FETCH;
      end
      S_EXECUTE: begin
        case (cls)
          C_ALU:   state_nxt = S_WRITEBACK;
          C_LOAD,
          C_STORE: state_nxt = S_MEMORY;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEMORY:    if (mem_ready) state_nxt = (cls == C_LOAD) ? S_WRITEBACK : S_FETCH;
      S_WRITEBACK: state_nxt = S_FETCH;
      S_TRAP:      state_nxt = S_TRAP;
      default:     state_nxt = S_FETCH;
    endcase
  end

  assign retire = (state == S_WRITEBACK)
               || (state == S_EXECUTE && cls == C_BRANCH)
               || (state == S_MEMORY && cls == C_STORE && mem_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_FETCH;
      cls         <= C_ALU;
      alu_cntrl   <= 32'd0;
      alu_src_imm <= 1'b0;
      trap        <= 1'b0;
      retired     <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) begin
        cls         <= dec_cls;
        alu_cntrl   <= {29'd0, dec_op};
        alu_src_imm <= dec_imm;
        if (!dec_legal && TRAP_ON_ILLEGAL) trap <= 1'b1;
      end
      if (retire) retired <= retired + 32'd1;
    end
  end

  // Gated by rst so no request or strobe leaks out while reset is held.
  assign mem_req   = rst && (state == S_FETCH || state == S_MEMORY);
  assign mem_we    = rst && (state == S_MEMORY) && (cls == C_STORE);
  assign ir_write  = rst && (state == S_FETCH) && mem_ready;
  assign pc_inc    = rst && (state == S_FETCH) && mem_ready;
  assign pc_branch = rst && (state == S_EXECUTE) && (cls == C_BRANCH) && alu_zero;
  assign reg_write = rst && (state == S_WRITEBACK);
  assign wb_sel    = rst && (state == S_WRITEBACK) && (cls == C_LOAD);

endmodule

// File: tb/tb_cpu_control.sv
// tb/tb_cpu_control.sv - self-checking bench for cpu_control
module tb_cpu_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'd0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;

  logic [31:0] alu_cntrl, retired;
  logic        alu_src_imm, mem_req, mem_we, ir_write, pc_inc, pc_branch, reg_write, wb_sel, trap;

  logic [31:0] n_retired, n_unused_alu;
  logic        n_mem_req, n_trap, n_reg_write;
  logic        n_unused_imm, n_unused_we, n_unused_irw, n_unused_pci, n_unused_br, n_unused_wb;

  cpu_control dut (
    .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .alu_cntrl(alu_cntrl), .alu_src_imm(alu_src_imm), .mem_req(mem_req), .mem_we(mem_we),
    .ir_write(ir_write), .pc_inc(pc_inc), .pc_branch(pc_branch), .reg_write(reg_write),
    .wb_sel(wb_sel), .trap(trap), .retired(retired)
  );

  cpu_control #(.TRAP_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .alu_cntrl(n_unused_alu), .alu_src_imm(n_unused_imm), .mem_req(n_mem_req), .mem_we(n_unused_we),
    .ir_write(n_unused_irw), .pc_inc(n_unused_pci), .pc_branch(n_unused_br), .reg_write(n_reg_write),
    .wb_sel(n_unused_wb), .trap(n_trap), .retired(n_retired)
  );

  always #5 clk = ~clk;

  // Instruction classes: 0 ALU, 1 load, 2 store, 3 branch, 4 illegal.
  typedef struct {
    logic [31:0] instr;
    logic        zero;
    int          fw;
    int          mw;
    int          cls;
    logic [31:0] alu;
    logic        imm;
  } vec_t;

  vec_t        vecs[$];
  int          passed = 0;
  int          total  = 0;
  logic [31:0] exp_ret  = 32'd0;
  logic [31:0] exp_nret = 32'd0;

  function automatic vec_t mk(logic [31:0] i, logic z, int fw, int mw, int c, logic [31:0] a, logic m);
    vec_t v;
    v.instr = i; v.zero = z; v.fw = fw; v.mw = mw; v.cls = c; v.alu = a; v.imm = m;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    else passed++;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Flags order: mem_req, mem_we, ir_write, pc_inc, pc_branch, reg_write, wb_sel, trap
  task automatic step(input logic rdy, input logic [7:0] exp, input string name);
    @(negedge clk);
    mem_ready = rdy;
    #1;
    check(name, 64'({mem_req, mem_we, ir_write, pc_inc, pc_branch, reg_write, wb_sel, trap}), 64'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("reset_async_flags", 64'({mem_req, mem_we, ir_write, pc_inc, pc_branch, reg_write, wb_sel, trap}), 64'(0));
    check("reset_async_regs", 64'({alu_cntrl, alu_src_imm}), 64'(0));
    check("reset_retired", 64'(retired), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_flags", 64'({mem_req, ir_write, trap, n_mem_req}), 64'(0));
    rst = 1'b1;
    mem_ready = 1'b0;
    exp_ret  = 32'd0;
    exp_nret = 32'd0;
  endtask

  task automatic run_instr(input vec_t v);
    instr    = v.instr;
    alu_zero = v.zero;
    for (int i = 0; i <= v.fw; i++)
      step(i == v.fw, {1'b1, 1'b0, i == v.fw, i == v.fw, 4'b0}, "fetch");
    step(rnd_bit(), 8'h00, "decode");
    if (v.cls == 4) begin
      step(rnd_bit(), 8'h01, "trap_enter");
      check("nop_refetch", 64'({n_mem_req, n_trap, n_reg_write}), 64'(3'b100));
      check("nop_retired", 64'(n_retired), 64'(exp_nret));
      step(rnd_bit(), 8'h01, "trap_hold");
      check("trap_retired", 64'(retired), 64'(exp_ret));
      do_reset();
      return;
    end
    step(rnd_bit(), {4'b0, (v.cls == 3) && v.zero, 3'b0}, "execute");
    check("alu_ctrl", 64'({v.alu != alu_cntrl, alu_src_imm}), 64'({1'b0, v.imm}));
    if (v.cls == 3) begin exp_ret++; exp_nret++; end
    if (v.cls == 1 || v.cls == 2) begin
      for (int i = 0; i <= v.mw; i++)
        step(i == v.mw, {1'b1, v.cls == 2, 6'b0}, "memory");
      if (v.cls == 2) begin exp_ret++; exp_nret++; end
    end
    if (v.cls == 0 || v.cls == 1) begin
      step(rnd_bit(), {5'b0, 1'b1, v.cls == 1, 1'b0}, "writeback");
      exp_ret++;
      exp_nret++;
    end
    @(posedge clk);
    #1;
    check("retired", 64'(retired), 64'(exp_ret));
  endtask

  initial begin
    vec_t v;
    vecs.push_back(mk(32'h40208033, 1'b0, 0, 0, 0, 32'd1, 1'b0)); // sub
    vecs.push_back(mk(32'h00208033, 1'b1, 1, 0, 0, 32'd0, 1'b0)); // add
    vecs.push_back(mk(32'h0020C033, 1'b0, 0, 0, 0, 32'd4, 1'b0)); // xor
    vecs.push_back(mk(32'h0020E033, 1'b0, 2, 0, 0, 32'd2, 1'b0)); // or
    vecs.push_back(mk(32'h0020F033, 1'b0, 0, 0, 0, 32'd3, 1'b0)); // and
    vecs.push_back(mk(32'h00108093, 1'b0, 0, 0, 0, 32'd0, 1'b1)); // addi
    vecs.push_back(mk(32'h0010C093, 1'b0, 0, 0, 0, 32'd4, 1'b1)); // xori
    vecs.push_back(mk(32'h0010E093, 1'b0, 0, 0, 0, 32'd2, 1'b1)); // ori
    vecs.push_back(mk(32'h0010F093, 1'b0, 0, 0, 0, 32'd3, 1'b1)); // andi
    vecs.push_back(mk(32'h00012083, 1'b0, 0, 3, 1, 32'd0, 1'b1)); // lw, 3 wait cycles
    vecs.push_back(mk(32'h00112023, 1'b0, 0, 0, 2, 32'd0, 1'b1)); // sw
    vecs.push_back(mk(32'h00000063, 1'b1, 0, 0, 3, 32'd1, 1'b0)); // beq taken
    vecs.push_back(mk(32'h00000063, 1'b0, 0, 0, 3, 32'd1, 1'b0)); // beq not taken
    vecs.push_back(mk(32'h00000000, 1'b0, 0, 0, 4, 32'd0, 1'b0)); // all-zero
    vecs.push_back(mk(32'h00209033, 1'b0, 0, 0, 4, 32'd0, 1'b0)); // sll
    vecs.push_back(mk(32'h02208033, 1'b0, 0, 0, 4, 32'd0, 1'b0)); // mul
    vecs.push_back(mk(32'h00010083, 1'b0, 0, 0, 4, 32'd0, 1'b0)); // lb
    vecs.push_back(mk(32'h00001063, 1'b0, 0, 0, 4, 32'd0, 1'b0)); // bne

    do_reset();
    foreach (vecs[k]) run_instr(vecs[k]);

    // Reset while FETCH waits for memory: no ir_write, fetch restarts.
    instr = 32'h00108093;
    step(1'b0, 8'b1000_0000, "fetch_wait");
    step(1'b0, 8'b1000_0000, "fetch_wait");
    do_reset();
    run_instr(vecs[5]);

    // Reset while a load waits in MEMORY.
    instr = 32'h00012083;
    step(1'b1, 8'b1011_0000, "lw_fetch");
    step(1'b0, 8'h00, "lw_decode");
    step(1'b0, 8'h00, "lw_execute");
    step(1'b0, 8'b1000_0000, "lw_mem_wait");
    do_reset();
    run_instr(vecs[5]);

    // Retired counter wrap.
    @(negedge clk);
    force dut.retired = 32'hFFFF_FFFF;
    #1;
    release dut.retired;
    check("retired_preload", 64'(retired), 64'(32'hFFFF_FFFF));
    exp_ret = 32'hFFFF_FFFF;
    run_instr(vecs[5]);
    check("retired_wrapped", 64'(exp_ret), 64'(0));

    for (int n = 0; n < 60; n++) begin
      logic [31:0] rnd, free;
      v    = vecs[$urandom_range(0, vecs.size() - 1)];
      rnd  = $urandom;
      free = (v.instr[6:0] == 7'b0110011) ? 32'h01FF_8F80 : 32'hFFFF_8F80;
      v.instr = (v.instr & ~free) | (rnd & free);
      v.zero  = rnd_bit();
      v.fw    = $urandom_range(0, 3);
      v.mw    = $urandom_range(0, 3);
      run_instr(v);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
